// File: rtl/data_mem_ctrl.sv
// Clocked RV32 data memory: valid/ready request port, one-cycle response,
// byte/half/word access with extension, error detection and a zero sweep after reset.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 128,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-2:0] DEPTH_L = (ADDR_WIDTH-1)'(DEPTH);
  localparam logic [IW-1:0] LAST_PTR = IW'(DEPTH - 1);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [IW-1:0] init_ptr_reg;
  logic          init_done_reg;
  logic          err_reg;
  logic          load_reg;
  logic [2:0]    funct3_reg;
  logic [1:0]    off_reg;
  logic [31:0]   rd_word_reg;
  logic [31:0]   mem [DEPTH];

  logic [ADDR_WIDTH-3:0] word_idx;
  logic [IW-1:0]         mem_idx;
  logic [1:0]            off;
  logic [1:0]            size;
  logic                  accept;
  logic                  req_err;
  logic                  store_en;
  logic                  load_en;
  logic                  sweep_en;
  logic [3:0]            st_be;
  logic [31:0]           st_lane;
  logic [31:0]           shifted;
  logic [31:0]           ld_ext;

  assign word_idx = req_addr[ADDR_WIDTH-1:2];
  assign mem_idx  = word_idx[IW-1:0];
  assign off      = req_addr[1:0];
  assign size     = req_funct3[1:0];
  assign accept   = (state_reg == S_IDLE) && req_valid;
  assign sweep_en = (state_reg == S_INIT);

  assign req_err = (size == 2'b11)
                 || (req_write && req_funct3[2])
                 || ((size == 2'b01) && off[0])
                 || ((size == 2'b10) && (off != 2'b00))
                 || ({1'b0, word_idx} >= DEPTH_L);

  assign store_en = accept && req_write && !req_err;
  assign load_en  = accept && !req_write && !req_err;

  // Per-lane byte enable and replicated store data; the enable picks the lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign st_be[gi] = (size == 2'b10)
                      || ((size == 2'b01) && (off[1] == LANE[1]))
                      || ((size == 2'b00) && (off == LANE));
      assign st_lane[8*gi +: 8] = (size == 2'b10) ? req_wdata[8*gi +: 8] :
                                  (size == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                                    req_wdata[7:0];
    end
  endgenerate

  // Array port kept free of the async reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (sweep_en) begin
        mem[init_ptr_reg] <= '0;
      end else if (store_en) begin
        for (int i = 0; i < 4; i++) begin
          if (st_be[i]) mem[mem_idx][8*i +: 8] <= st_lane[8*i +: 8];
        end
      end
      if (load_en) rd_word_reg <= mem[mem_idx];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_INIT:  if (init_ptr_reg == LAST_PTR) state_next = S_IDLE;
      S_IDLE:  if (req_valid) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= INIT_CLEAR ? S_INIT : S_IDLE;
      init_ptr_reg  <= '0;
      init_done_reg <= !INIT_CLEAR;
      err_reg       <= 1'b0;
      load_reg      <= 1'b0;
      funct3_reg    <= 3'b000;
      off_reg       <= 2'b00;
    end else begin
      state_reg <= state_next;
      if (sweep_en) begin
        init_ptr_reg <= init_ptr_reg + 1'b1;
        if (init_ptr_reg == LAST_PTR) init_done_reg <= 1'b1;
      end
      if (accept) begin
        err_reg    <= req_err;
        load_reg   <= load_en;
        funct3_reg <= req_funct3;
        off_reg    <= off;
      end
    end
  end

  assign shifted = rd_word_reg >> {off_reg, 3'b000};

  always_comb begin
    ld_ext = shifted;
    case (funct3_reg[1:0])
      2'b00:   ld_ext = funct3_reg[2] ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_ext = funct3_reg[2] ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  assign req_ready = (state_reg == S_IDLE);
  assign rsp_valid = (state_reg == S_RESP);
  assign rsp_err   = rsp_valid && err_reg;
  assign rsp_rdata = (rsp_valid && load_reg) ? ld_ext : 32'h0;
  assign init_done = init_done_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, randomized traffic against a
// byte-level memory model, and reset during the response and during the sweep.
module tb_data_mem_ctrl;

  localparam int AW    = 9;
  localparam int DEPTH = 120;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          init_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl [DEPTH*4];

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [18];

  data_mem_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .INIT_CLEAR(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: little-endian byte array and the access rules in plain arithmetic.
  function automatic logic mdl_err(input logic wr, input logic [2:0] f3, input logic [8:0] a);
    int nb = 1 << f3[1:0];
    if (f3[1:0] == 2'b11) return 1'b1;
    if (wr && f3[2]) return 1'b1;
    if ((int'(a) % nb) != 0) return 1'b1;
    if ((int'(a) / 4) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [8:0] a);
    int nb = 1 << f3[1:0];
    logic [31:0] v = 32'h0;
    logic [31:0] mask;
    for (int i = 0; i < nb; i++) v = v | (32'(mdl[int'(a) + i]) << (8*i));
    if (nb < 4 && !f3[2] && v[8*nb-1]) begin
      mask = (32'h1 << (8*nb)) - 32'h1;
      v = v | ~mask;
    end
    return v;
  endfunction

  task automatic mdl_store(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd);
    int nb = 1 << f3[1:0];
    for (int i = 0; i < nb; i++) mdl[int'(a) + i] = wd[8*i +: 8];
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < DEPTH*4; i++) mdl[i] = 8'h00;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'b0, req_ready}, 32'h1);
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [8:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
    wait_ready();
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rsp_valid_pulse", {31'b0, rsp_valid}, 32'h1);
    rd = rsp_rdata;
    er = rsp_err;
    $display("txn wr=%0d f3=%b addr=%h wdata=%h -> rdata=%h err=%0d", wr, f3, a, wd, rd, er);
    @(negedge clk);
    chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'h0);
    chk("idle_rdata_zero", rsp_rdata, 32'h0);
  endtask

  task automatic measure_init();
    int cnt = 0;
    logic ready_seen = 1'b0;
    while (!init_done && cnt < DEPTH + 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (req_ready && !init_done) ready_seen = 1'b1;
    end
    chk("init_cycles", 32'(cnt), 32'(DEPTH));
    chk("ready_during_init", {31'b0, ready_seen}, 32'h0);
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [8:0] a,
                              input logic [31:0] wd, input logic [31:0] er, input logic ee);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = a; v.wd = wd; v.exp_rd = er; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] exp_rd;
    logic        exp_er;

    tbl[0]  = mk(1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0,        0);
    tbl[1]  = mk(0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 0);
    tbl[2]  = mk(1, 3'b000, 9'h013, 32'h00000080, 32'h0,        0);
    tbl[3]  = mk(0, 3'b000, 9'h013, 32'h0,        32'hFFFFFF80, 0);
    tbl[4]  = mk(0, 3'b100, 9'h013, 32'h0,        32'h00000080, 0);
    tbl[5]  = mk(0, 3'b010, 9'h010, 32'h0,        32'h80ADBEEF, 0);
    tbl[6]  = mk(1, 3'b001, 9'h022, 32'h00008001, 32'h0,        0);
    tbl[7]  = mk(0, 3'b001, 9'h022, 32'h0,        32'hFFFF8001, 0);
    tbl[8]  = mk(0, 3'b101, 9'h022, 32'h0,        32'h00008001, 0);
    tbl[9]  = mk(0, 3'b010, 9'h020, 32'h0,        32'h80010000, 0);
    tbl[10] = mk(0, 3'b010, 9'h011, 32'h0,        32'h0,        1);
    tbl[11] = mk(1, 3'b001, 9'h023, 32'h0000FFFF, 32'h0,        1);
    tbl[12] = mk(0, 3'b011, 9'h010, 32'h0,        32'h0,        1);
    tbl[13] = mk(1, 3'b100, 9'h010, 32'h000000AA, 32'h0,        1);
    tbl[14] = mk(0, 3'b010, 9'h010, 32'h0,        32'h80ADBEEF, 0);
    tbl[15] = mk(1, 3'b010, 9'h1DC, 32'hCAFEF00D, 32'h0,        0);
    tbl[16] = mk(0, 3'b010, 9'h1DC, 32'h0,        32'hCAFEF00D, 0);
    tbl[17] = mk(0, 3'b010, 9'h1E0, 32'h0,        32'h0,        1);

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'b000; req_addr = '0; req_wdata = 32'h0;
    mdl_clear();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   {31'b0, rsp_err}, 32'h0);
    chk("rst_init_done", {31'b0, init_done}, 32'h0);
    reset = 1'b0;
    measure_init();

    do_req(0, 3'b010, 9'h0A4, 32'h0, rd, er);
    chk("post_init_lw", rd, 32'h0);

    for (int i = 0; i < 18; i++) begin
      do_req(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
      if (tbl[i].wr && !mdl_err(tbl[i].wr, tbl[i].f3, tbl[i].addr))
        mdl_store(tbl[i].f3, tbl[i].addr, tbl[i].wd);
    end

    for (int i = 0; i < 300; i++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [8:0]  a;
      logic [31:0] wd;
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) a = a & ~9'((1 << f3[1:0]) - 1);
      wd = $urandom;
      exp_er = mdl_err(wr, f3, a);
      exp_rd = (wr || exp_er) ? 32'h0 : mdl_load(f3, a);
      do_req(wr, f3, a, wd, rd, er);
      chk("rand_rdata", rd, exp_rd);
      chk("rand_err", {31'b0, er}, {31'b0, exp_er});
      if (wr && !exp_er) mdl_store(f3, a, wd);
    end

    // Reset in the middle of a response, then again partway through the sweep.
    do_req(1, 3'b010, 9'h040, 32'h12345678, rd, er);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 9'h040;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("resp_before_reset_valid", {31'b0, rsp_valid}, 32'h1);
    chk("resp_before_reset_rdata", rsp_rdata, 32'h12345678);
    reset = 1'b1;
    #1;
    chk("reset_drops_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_drops_rdata", rsp_rdata, 32'h0);
    chk("reset_clears_done", {31'b0, init_done}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_sweep_ready", {31'b0, req_ready}, 32'h0);
    reset = 1'b1;
    #1;
    chk("mid_sweep_done", {31'b0, init_done}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mdl_clear();
    measure_init();
    do_req(0, 3'b010, 9'h040, 32'h0, rd, er);
    chk("after_reset_lw40", rd, 32'h0);
    do_req(0, 3'b010, 9'h010, 32'h0, rd, er);
    chk("after_reset_lw10", rd, 32'h0);
    do_req(0, 3'b010, 9'h1DC, 32'h0, rd, er);
    chk("after_reset_lw1dc", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
